// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input_debounce block.
package debounce_pkg;

  localparam int unsigned DB_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

endpackage : debounce_pkg

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchronizer, four-state FSM, stability counter.
// Edge pulse flops exist only when INPUT_DEBOUNCE_EDGE_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sw_out_q, sw_out_d;
`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
`endif

  assign s = sync_q[1];

  // Next-state: a level is accepted only after DB_CYCLES consecutive matching samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sw_out_d = sw_out_q;
`ifdef INPUT_DEBOUNCE_EDGE_EN
    rise_d   = 1'b0;
    fall_d   = 1'b0;
`endif
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          sw_out_d = 1'b1;
`ifdef INPUT_DEBOUNCE_EDGE_EN
          rise_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          sw_out_d = 1'b0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
          fall_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      sw_out_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], sw_in};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_out_q <= sw_out_d;
    end
  end

`ifdef INPUT_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign sw_out = sw_out_q;

endmodule : debounce_ch

// File: rtl/input_debounce.sv
// N_CH-channel switch debouncer feeding the gate stage.
// Define INPUT_DEBOUNCE_EDGE_EN to enable the rise/fall pulse outputs.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_in (sw_in[i]),
      .sw_out(sw_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule : input_debounce

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce (N_CH=2, DB_CYCLES=4).
module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] sw_in;
  logic [1:0] sw_out;
  logic [1:0] rise;
  logic [1:0] fall;

  int checks = 0;
  int errors = 0;

  input_debounce #(
    .N_CH     (2),
    .DB_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .sw_out(sw_out),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] edge_exp(input logic [1:0] v);
    return EDGE_EN ? v : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_sw,
                         input logic [1:0] e_rise, input logic [1:0] e_fall);
    chk({tag, " sw_out"}, sw_out, e_sw);
    chk({tag, " rise"}, rise, edge_exp(e_rise));
    chk({tag, " fall"}, fall, edge_exp(e_fall));
  endtask

  // Advance past one rising edge and sample on the following falling edge.
  task automatic step_chk(input string tag, input logic [1:0] e_sw,
                          input logic [1:0] e_rise, input logic [1:0] e_fall);
    @(negedge clk);
    chk_all(tag, e_sw, e_rise, e_fall);
  endtask

  // Drive v and expect a clean debounced transition from prev to v after edge 6.
  task automatic settle(input string tag, input logic [1:0] prev, input logic [1:0] v);
    logic [1:0] up, dn;
    up = v & ~prev;
    dn = prev & ~v;
    sw_in = v;
    for (int k = 1; k <= 8; k++)
      step_chk($sformatf("%s k=%0d", tag, k), (k >= 6) ? v : prev,
               (k == 6) ? up : 2'b00, (k == 6) ? dn : 2'b00);
  endtask

  initial begin
    bit pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with both inputs high
    rst_n = 1'b0;
    sw_in = 2'b11;
    #2;
    chk_all("reset t0", 2'b00, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    chk_all("reset held", 2'b00, 2'b00, 2'b00);

    // Release: both channels accepted 6 edges later, single rise pulse
    rst_n = 1'b1;
    settle("rel", 2'b00, 2'b11);
    settle("both low", 2'b11, 2'b00);

    // Clean step on ch0
    settle("clean", 2'b00, 2'b01);
    settle("clean low", 2'b01, 2'b00);

    // Bounce on ch0: raw 1,0,1,1,0 then held high; FSM sees raw two edges late
    for (int k = 1; k <= 14; k++) begin
      sw_in = {1'b0, (k <= 5) ? pat[k-1] : 1'b1};
      step_chk($sformatf("bounce k=%0d", k), (k >= 11) ? 2'b01 : 2'b00,
               (k == 11) ? 2'b01 : 2'b00, 2'b00);
    end
    settle("bounce low", 2'b01, 2'b00);

    // Glitch on ch1: high for only 3 cycles
    for (int k = 1; k <= 10; k++) begin
      sw_in = (k <= 3) ? 2'b10 : 2'b00;
      step_chk($sformatf("glitch k=%0d", k), 2'b00, 2'b00, 2'b00);
    end

    // Mid-count reset on ch0
    sw_in = 2'b01;
    for (int k = 1; k <= 3; k++)
      step_chk($sformatf("midrst pre k=%0d", k), 2'b00, 2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    chk_all("midrst asserted", 2'b00, 2'b00, 2'b00);
    step_chk("midrst edge4", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++)
      step_chk($sformatf("midrst post k=%0d", k), (k >= 6) ? 2'b01 : 2'b00,
               (k == 6) ? 2'b01 : 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_input_debounce

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent input channels feeding the downstream and/or/not gate inputs.
REQ-002 SHALL have parameter DB_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sw_in, input, N_CH bits: raw, asynchronous, possibly bouncing switch levels.
REQ-006 SHALL have port sw_out, output, N_CH bits: registered, debounced levels for the gate stage.
REQ-007 SHALL have port rise, output, N_CH bits: one-cycle pulse per channel on an accepted 0->1 change.
REQ-008 SHALL have port fall, output, N_CH bits: one-cycle pulse per channel on an accepted 1->0 change.

Function
REQ-009 SHALL pass each sw_in bit through a two-flop synchronizer; the second flop output is the sample s.
REQ-010 SHALL run one independent four-state machine per channel: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-011 In STABLE_LO with s=1, the FSM SHALL go to WAIT_HI with cnt=1; with s=0 it SHALL stay put with cnt=0.
REQ-012 In WAIT_HI with s=1 and cnt==DB_CYCLES-1, the FSM SHALL go to STABLE_HI, set sw_out=1 and assert rise for exactly one cycle.
REQ-013 In WAIT_HI with s=1 and cnt<DB_CYCLES-1, the FSM SHALL increment cnt; with s=0 it SHALL return to STABLE_LO with cnt=0 and no output change.
REQ-014 STABLE_HI and WAIT_LO SHALL mirror REQ-011..013 with polarity inverted, ending in sw_out=0 and a one-cycle fall pulse.
REQ-015 Latency: for a clean raw step first captured at edge 1, sw_out SHALL change after edge DB_CYCLES+2 (6 edges at default).
REQ-016 Any s glitch shorter than DB_CYCLES consecutive cycles SHALL produce no change on sw_out, rise or fall.
REQ-017 The counter SHALL be $clog2(DB_CYCLES+1) bits wide and SHALL never wrap; it is cleared on every return to a STABLE state.
REQ-018 rise[i] and fall[i] SHALL never be asserted in the same cycle; different channels MAY pulse in the same cycle.
REQ-019 rise/fall SHALL be registered and asserted in the same cycle that sw_out shows the new level.

Reset
REQ-020 While rst_n=0, synchronizer flops, sw_out, rise, fall and cnt SHALL be 0 and every FSM SHALL be in STABLE_LO, independent of clk.
REQ-021 Reset asserted mid-WAIT SHALL discard the partial count; after release with sw_in held high, sw_out SHALL rise a full REQ-015 latency later.
REQ-022 Reset release SHALL emit no rise/fall pulse on the first edge, whatever the sw_in level.

Configuration
REQ-023 With macro INPUT_DEBOUNCE_EDGE_EN defined, rise and fall SHALL behave per REQ-012/014/018/019.
REQ-024 Without INPUT_DEBOUNCE_EDGE_EN, rise and fall ports SHALL remain present but be tied to constant 0, and no edge registers SHALL be synthesized; sw_out behaviour is unchanged.

Structure
REQ-025 A shared package debounce_pkg SHALL hold the FSM state typedef (2-bit enum: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO) and the DB_CYCLES default constant.
REQ-026 Per-channel logic (synchronizer, FSM, counter, edge flops) SHALL live in sub-module debounce_ch, instantiated N_CH times by a generate loop.

Verification
REQ-027 Reset: hold rst_n=0 with sw_in=2'b11 -> sw_out=0, rise=0, fall=0; release -> sw_out=2'b11 exactly 6 edges later, with a single rise=2'b11 pulse in that cycle.
REQ-028 Clean step: ch0 0->1 at edge 1, held -> sw_out[0]=1 and rise[0]=1 after edge 6, rise[0]=0 after edge 7.
REQ-029 Bounce: ch0 toggles 1,0,1,1,0 on successive cycles, then holds 1 -> no output change until 4 consecutive high samples are seen, then exactly one rise[0] pulse.
REQ-030 Glitch: ch1 high for 3 cycles only (DB_CYCLES=4) -> sw_out[1] stays 0; no pulses.
REQ-031 Mid-count reset: ch0 high, rst_n pulsed low at edge 4 -> sw_out[0]=0 and no pulse; sw_out[0]=1 at 6 edges after release.
REQ-032 Build without INPUT_DEBOUNCE_EDGE_EN, rerun REQ-028 -> identical sw_out timing; rise=fall=0 throughout.
